kbd_seg_ctrl: RTL and testbench

KBD_SEG_CTRL -- requirements
Module: kbd_seg_ctrl

---
 rtl/kbd_seg_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_kbd_seg_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_seg_ctrl.sv
// kbd_seg_ctrl
//   Pops PS/2 scan codes from a keyboard FIFO, tracks the currently held key
//   and a press counter, and drives eight seven-segment digits.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   data[7:0]    scan code at FIFO head, valid while ready=1
//   ready        FIFO non-empty
//   overflow     FIFO overflow indication
//   nextdata_n   active-low pop strobe to FIFO (one cycle per byte)
//   seg0..seg7   digits, bit7..0 = a,b,c,d,e,f,g,dp, 0 = lit
//                seg1:seg0 current code, seg3:seg2 ASCII, seg5:seg4 press
//                count, seg6 blank, seg7 dp = overflow seen
module kbd_seg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5,
  output logic [7:0] seg6,
  output logic [7:0] seg7
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] BLANK = 8'hFF;

  state_t          state_q, state_d;
  logic            nextdata_n_q, nextdata_n_d;
  logic            held_q, held_d;
  logic [7:0]      cur_code_q, cur_code_d;
  logic            cur_ext_q, cur_ext_d;
  logic            break_pending_q, break_pending_d;
  logic            ext_pending_q, ext_pending_d;
  logic [7:0]      press_cnt_q, press_cnt_d;
  logic            ovf_flag_q, ovf_flag_d;
  logic [7:0][7:0] seg_q, seg_d;
  logic            take;
  logic [8:0]      ascii;
  logic            ascii_hit;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03;  4'h1: s = 8'h9F;  4'h2: s = 8'h25;  4'h3: s = 8'h0D;
      4'h4: s = 8'h99;  4'h5: s = 8'h49;  4'h6: s = 8'h41;  4'h7: s = 8'h1F;
      4'h8: s = 8'h01;  4'h9: s = 8'h09;  4'hA: s = 8'h11;  4'hB: s = 8'hC1;
      4'hC: s = 8'h63;  4'hD: s = 8'h85;  4'hE: s = 8'h61;  default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Returns {hit, ascii}.
  function automatic logic [8:0] ascii_lookup(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      8'h45: r = {1'b1, 8'h30};  8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};  8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};  8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};  8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};  8'h46: r = {1'b1, 8'h39};
      8'h1C: r = {1'b1, 8'h41};  8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43};  8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45};  8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47};  8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49};  8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B};  8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D};  8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F};  8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51};  8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53};  8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55};  8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57};  8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59};  8'h1A: r = {1'b1, 8'h5A};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Consumer FSM plus key-state update. The byte is decoded straight off
  // the FIFO head in the cycle the FSM leaves IDLE, so key state lands on
  // the same edge that starts the pop.
  always_comb begin
    state_d         = state_q;
    nextdata_n_d    = 1'b1;
    held_d          = held_q;
    cur_code_d      = cur_code_q;
    cur_ext_d       = cur_ext_q;
    break_pending_d = break_pending_q;
    ext_pending_d   = ext_pending_q;
    press_cnt_d     = press_cnt_q;
    ovf_flag_d      = ovf_flag_q | overflow;
    take            = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready) begin
          state_d      = POP;
          nextdata_n_d = 1'b0;
          take         = 1'b1;
        end
      end
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (take) begin
      if (data == 8'hF0) begin
        break_pending_d = 1'b1;
      end else if (data == 8'hE0) begin
        ext_pending_d = 1'b1;
      end else begin
        if (break_pending_q) begin
          if (data == cur_code_q && ext_pending_q == cur_ext_q) begin
            held_d = 1'b0;
          end
        end else if (!(held_q && data == cur_code_q && ext_pending_q == cur_ext_q)) begin
          cur_code_d  = data;
          cur_ext_d   = ext_pending_q;
          held_d      = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end
        break_pending_d = 1'b0;
        ext_pending_d   = 1'b0;
      end
    end
  end

  always_comb begin
    ascii     = ascii_lookup(cur_code_q);
    ascii_hit = ascii[8] & ~cur_ext_q;
    seg_d     = '1;
    if (held_q) begin
      seg_d[0] = hex_seg(cur_code_q[3:0]);
      seg_d[1] = hex_seg(cur_code_q[7:4]);
      if (ascii_hit) begin
        seg_d[2] = hex_seg(ascii[3:0]);
        seg_d[3] = hex_seg(ascii[7:4]);
      end
    end
    seg_d[4] = hex_seg(press_cnt_q[3:0]);
    seg_d[5] = hex_seg(press_cnt_q[7:4]);
    seg_d[6] = BLANK;
    seg_d[7] = {7'h7F, ~ovf_flag_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      nextdata_n_q    <= 1'b1;
      held_q          <= 1'b0;
      cur_code_q      <= '0;
      cur_ext_q       <= 1'b0;
      break_pending_q <= 1'b0;
      ext_pending_q   <= 1'b0;
      press_cnt_q     <= '0;
      ovf_flag_q      <= 1'b0;
      seg_q           <= {BLANK, BLANK, 8'h03, 8'h03, BLANK, BLANK, BLANK, BLANK};
    end else begin
      state_q         <= state_d;
      nextdata_n_q    <= nextdata_n_d;
      held_q          <= held_d;
      cur_code_q      <= cur_code_d;
      cur_ext_q       <= cur_ext_d;
      break_pending_q <= break_pending_d;
      ext_pending_q   <= ext_pending_d;
      press_cnt_q     <= press_cnt_d;
      ovf_flag_q      <= ovf_flag_d;
      seg_q           <= seg_d;
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

// File: tb/tb_kbd_seg_ctrl.sv
// Directed bench for kbd_seg_ctrl: a queue models the keyboard FIFO,
// expected digit values are hand-computed from the hex font.
module tb_kbd_seg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  kbd_seg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .seg4       (seg4),
    .seg5       (seg5),
    .seg6       (seg6),
    .seg7       (seg7)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] font(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
          8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    return t[n];
  endfunction

  // FIFO model: pops on a low strobe, presents the head on each negedge.
  logic [7:0] fifo_q[$];
  int cyc = 0;
  int last_pop = -100;
  int pulses = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst && nextdata_n === 1'b0) begin
      pulses++;
      check("pop_gap", ((cyc - last_pop) >= 3) ? 8'd1 : 8'd0, 8'd1);
      last_pop = cyc;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    ready = (fifo_q.size() != 0);
    data  = ready ? fifo_q[0] : 8'h00;
  end

  task automatic do_reset();
    rst = 1'b1;
    overflow = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulses = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (fifo_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 8'(fifo_q.size()), 8'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_cur(input string tag, input logic [7:0] s1, input logic [7:0] s0,
                           input logic [7:0] s3, input logic [7:0] s2,
                           input logic [7:0] s5, input logic [7:0] s4);
    check({tag, "_seg1"}, seg1, s1);
    check({tag, "_seg0"}, seg0, s0);
    check({tag, "_seg3"}, seg3, s3);
    check({tag, "_seg2"}, seg2, s2);
    check({tag, "_seg5"}, seg5, s5);
    check({tag, "_seg4"}, seg4, s4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cnt;
    int n;

    // Reset and idle
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check_cur("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03);
    check("rst_seg6", seg6, 8'hFF);
    check("rst_seg7", seg7, 8'hFF);
    check("rst_ndn", {7'd0, nextdata_n}, 8'd1);
    check("rst_pulses", 8'(pulses), 8'd0);

    // Make 1C then break F0 1C
    do_reset();
    fifo_q.push_back(8'h1C);
    drain();
    check_cur("mk1c", 8'h9F, 8'h63, 8'h99, 8'h9F, 8'h03, 8'h9F);
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h1C);
    drain();
    check_cur("brk1c", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h9F);
    check("brk_pulses", 8'(pulses), 8'd3);

    // Typematic repeat then new key 32
    do_reset();
    repeat (3) fifo_q.push_back(8'h1C);
    drain();
    check_cur("typ", 8'h9F, 8'h63, 8'h99, 8'h9F, 8'h03, 8'h9F);
    fifo_q.push_back(8'h32);
    drain();
    check_cur("mk32", 8'h0D, 8'h25, 8'h99, 8'h25, 8'h03, 8'h25);

    // Extended key E0 75, non-ext break ignored, ext break releases
    do_reset();
    fifo_q.push_back(8'hE0);
    fifo_q.push_back(8'h75);
    drain();
    check_cur("ext75", 8'h1F, 8'h49, 8'hFF, 8'hFF, 8'h03, 8'h9F);
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h75);
    drain();
    check_cur("nbrk75", 8'h1F, 8'h49, 8'hFF, 8'hFF, 8'h03, 8'h9F);
    fifo_q.push_back(8'hE0);
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h75);
    drain();
    check_cur("ebrk75", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h9F);

    // 256 press/release pairs of key 45: counter wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cnt = 8'(i + 1);
      fifo_q.push_back(8'h45);
      drain();
      check_cur("p45", 8'h99, 8'h49, 8'h0D, 8'h03, font(cnt[7:4]), font(cnt[3:0]));
      fifo_q.push_back(8'hF0);
      fifo_q.push_back(8'h45);
      drain();
      check("r45_seg0", seg0, 8'hFF);
    end
    check("wrap_seg5", seg5, 8'h03);
    check("wrap_seg4", seg4, 8'h03);

    // Overflow pulse, then reset in the middle of a pop
    do_reset();
    @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ovf_seg7", seg7, 8'hFE);
    fifo_q.push_back(8'h1C);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (nextdata_n !== 1'b0 && n < 50);
    check("pop_seen", {7'd0, nextdata_n}, 8'd0);
    rst = 1'b1;
    #1;
    check("rstpop_ndn", {7'd0, nextdata_n}, 8'd1);
    check("rstpop_seg7", seg7, 8'hFF);
    check("rstpop_seg4", seg4, 8'h03);
    fifo_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_seg0", seg0, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
